sram_like_arbiter: RTL and testbench

- Shares one sram-like memory port between the instruction-fetch master and the data-access master of the mips core.
- It sits between the core's inst/data sram-like request interfaces and the single bus port toward the cache/AXI bridge.
- Arbitration is fixed-priority with data favoured and a starvation guard for fetch. At most one transaction is outstanding at any time.
- Masters use req/addr_ok for the address phase and data_ok for the response phase.

---
 rtl/sram_like_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// Shares one sram-like bus port between the fetch (inst) and data masters.
// Data has fixed priority. Fetch is forced through after MAX_DATA_STREAK
// consecutive data grants that were taken while fetch was waiting.
// Only one access is ever outstanding, so the response is always routed
// back to the master recorded in owner_q.
module sram_like_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              resetn,

  // instruction-fetch master
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  // data-access master
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  // shared port toward the cache / AXI bridge
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;  // free, arbitrating combinationally
  localparam logic [1:0] ST_REQ  = 2'd1;  // grant locked, waiting bus_addr_ok
  localparam logic [1:0] ST_WAIT = 2'd2;  // address taken, waiting bus_data_ok

  // master identifiers used for both grant and owner
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  // streak counter is 4 bits wide, enough for the 1..15 limit range
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  logic [1:0] state_q,  state_d;
  logic [1:0] grant_q,  grant_d;
  logic [1:0] owner_q,  owner_d;
  logic [3:0] streak_q, streak_d;

  logic any_req;
  logic data_wins;
  logic sel_data;    // 1: the bus currently carries the data master's fields
  logic issuing;     // bus_req before reset gating
  logic accept;      // address phase completes this cycle
  logic respond;     // response phase completes this cycle

  assign any_req = inst_req | data_req;

  // Data wins unless fetch is pending and has been passed over too often.
  assign data_wins = data_req & ~(inst_req & (streak_q == STREAK_MAX));

  // Select which master drives the bus and whether a request is presented.
  always_comb begin
    sel_data = 1'b0;
    issuing  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issuing  = any_req;
        sel_data = data_wins;
      end
      ST_REQ: begin
        issuing  = 1'b1;
        sel_data = (grant_q == OWN_DATA);
      end
      default: begin
        issuing  = 1'b0;
        sel_data = 1'b0;
      end
    endcase
  end

  // Holding resetn low forces every handshake output low at once, without
  // waiting for the state registers to be observed.
  assign bus_req = issuing & resetn;
  assign accept  = bus_req & bus_addr_ok;
  assign respond = resetn & (state_q == ST_WAIT) & bus_data_ok;

  // Request fields follow the selected master; they are zero while idle.
  assign bus_wr    = bus_req & (sel_data ? data_wr : inst_wr);
  assign bus_size  = bus_req ? (sel_data ? data_size  : inst_size)  : 2'd0;
  assign bus_addr  = bus_req ? (sel_data ? data_addr  : inst_addr)  : '0;
  assign bus_wdata = bus_req ? (sel_data ? data_wdata : inst_wdata) : '0;

  // Address acknowledge goes only to the master whose fields are on the bus.
  assign inst_addr_ok = accept & ~sel_data;
  assign data_addr_ok = accept &  sel_data;

  // Response goes only to the owner of the outstanding access.
  assign inst_data_ok = respond & (owner_q == OWN_INST);
  assign data_data_ok = respond & (owner_q == OWN_DATA);

  // Read data is broadcast; it is qualified by the matching data_ok.
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  // Next-state logic for the FSM, grant/owner tracking and fetch streak.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    streak_d = streak_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          if (bus_addr_ok) begin
            state_d = ST_WAIT;
            owner_d = sel_data ? OWN_DATA : OWN_INST;
          end else begin
            state_d = ST_REQ;
            grant_d = sel_data ? OWN_DATA : OWN_INST;
          end
        end
      end
      ST_REQ: begin
        if (bus_addr_ok) begin
          state_d = ST_WAIT;
          owner_d = grant_q;
          grant_d = OWN_NONE;
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = OWN_NONE;
        owner_d = OWN_NONE;
      end
    endcase

    // Count data wins only while fetch is actually being held off.
    if (accept) begin
      if (sel_data && inst_req) begin
        if (streak_q != STREAK_MAX) begin
          streak_d = streak_q + 4'd1;
        end
      end else begin
        streak_d = 4'd0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      grant_q  <= OWN_NONE;
      owner_q  <= OWN_NONE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter
// Directed-vector bench for sram_like_arbiter. Inputs change 1 ns after the
// rising edge, outputs are compared 3 ns later, well away from the edge.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  sram_like_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // single comparison point for every check in the bench
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
  endtask

  // bound on total run time
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_inst;
    idle_inputs();

    // ---------------- reset: outputs low even with requests and acks present
    resetn = 0;
    inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
    #3;
    check("rst_bus_req",     bus_req,      0);
    check("rst_inst_addrok", inst_addr_ok, 0);
    check("rst_data_addrok", data_addr_ok, 0);
    check("rst_inst_dataok", inst_data_ok, 0);
    check("rst_data_dataok", data_data_ok, 0);
    check("rst_bus_addr",    bus_addr,     0);
    tick();
    idle_inputs();
    resetn = 1;
    tick();

    // ---------------- single fetch
    inst_req = 1; inst_addr = 32'hBFC0_0000; bus_addr_ok = 1;
    #3;
    check("f_bus_req",      bus_req,      1);
    check("f_bus_addr",     bus_addr,     32'hBFC0_0000);
    check("f_bus_wr",       bus_wr,       0);
    check("f_bus_size",     bus_size,     2);
    check("f_inst_addrok",  inst_addr_ok, 1);
    check("f_data_addrok",  data_addr_ok, 0);
    tick();
    inst_req = 0; bus_addr_ok = 0;
    #3;
    check("f_c1_bus_req",   bus_req,      0);
    check("f_c1_dataok",    inst_data_ok, 0);
    tick();
    bus_data_ok = 1; bus_rdata = 32'h3C08_0001;
    #3;
    check("f_inst_dataok",  inst_data_ok, 1);
    check("f_inst_rdata",   inst_rdata,   32'h3C08_0001);
    check("f_data_dataok",  data_data_ok, 0);
    $display("txn fetch  addr=bfc00000 rdata=%08h", inst_rdata);
    tick();
    idle_inputs();

    // ---------------- contention: data first, fetch after a bubble
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 1; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
    bus_addr_ok = 1;
    #3;
    check("c_bus_addr",     bus_addr,     32'h8000_1000);
    check("c_bus_wr",       bus_wr,       1);
    check("c_bus_wdata",    bus_wdata,    32'hDEAD_BEEF);
    check("c_data_addrok",  data_addr_ok, 1);
    check("c_inst_addrok",  inst_addr_ok, 0);
    tick();
    data_req = 0; data_wr = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #3;
    check("c_wait_bus_req", bus_req,      0);
    check("c_data_dataok",  data_data_ok, 1);
    check("c_inst_dataok",  inst_data_ok, 0);
    $display("txn write  addr=80001000 wdata=deadbeef");
    tick();
    bus_data_ok = 0;
    #3;
    check("c_inst_issue",   bus_req,      1);
    check("c_inst_addr",    bus_addr,     32'hBFC0_0004);
    check("c_inst_noack",   inst_addr_ok, 0);
    tick();
    bus_addr_ok = 1;
    #3;
    check("c_inst_addrok",  inst_addr_ok, 1);
    check("c_inst_addr2",   bus_addr,     32'hBFC0_0004);
    tick();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1234_5678;
    #3;
    check("c_inst_dataok2", inst_data_ok, 1);
    $display("txn fetch  addr=bfc00004 rdata=%08h", inst_rdata);
    tick();
    idle_inputs();

    // ---------------- grant lock: inst held in REQ while data arrives
    inst_req = 1; inst_addr = 32'hBFC0_0100;
    #3;
    check("g_c0_addr",      bus_addr,     32'hBFC0_0100);
    tick();
    data_req = 1; data_addr = 32'h8000_2000;
    for (int c = 1; c <= 2; c++) begin
      #3;
      check("g_hold_addr",    bus_addr,     32'hBFC0_0100);
      check("g_hold_data_ok", data_addr_ok, 0);
      check("g_hold_req",     bus_req,      1);
      tick();
    end
    bus_addr_ok = 1;
    #3;
    check("g_inst_addrok",  inst_addr_ok, 1);
    check("g_data_addrok",  data_addr_ok, 0);
    check("g_addr",         bus_addr,     32'hBFC0_0100);
    tick();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #3;
    check("g_inst_dataok",  inst_data_ok, 1);
    check("g_data_dataok",  data_data_ok, 0);
    $display("txn fetch  addr=bfc00100 (locked)");
    tick();
    bus_data_ok = 0; bus_addr_ok = 1;
    #3;
    check("g_data_addr",    bus_addr,     32'h8000_2000);
    check("g_data_addrok2", data_addr_ok, 1);
    tick();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #3;
    check("g_data_dataok2", data_data_ok, 1);
    $display("txn read   addr=80002000");
    tick();
    idle_inputs();

    // ---------------- starvation guard: pattern D D D D I repeated
    inst_req = 1; inst_addr = 32'h1000_0000;
    data_req = 1; data_addr = 32'h2000_0000;
    for (int t = 0; t < 10; t++) begin
      exp_inst = ((t % 5) == 4);
      bus_addr_ok = 1; bus_data_ok = 0;
      #3;
      check("s_inst_addrok", inst_addr_ok, exp_inst);
      check("s_data_addrok", data_addr_ok, !exp_inst);
      check("s_bus_addr",    bus_addr,     exp_inst ? 32'h1000_0000 : 32'h2000_0000);
      tick();
      bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'(t);
      #3;
      check("s_inst_dataok", inst_data_ok, exp_inst);
      check("s_data_dataok", data_data_ok, !exp_inst);
      $display("txn streak #%0d winner=%s", t, exp_inst ? "inst" : "data");
      tick();
    end
    idle_inputs();

    // ---------------- reset while waiting for the response
    data_req = 1; data_addr = 32'h3000_0000; bus_addr_ok = 1;
    #3;
    check("r_data_addrok",  data_addr_ok, 1);
    tick();
    data_req = 0; bus_addr_ok = 0;
    #3;
    check("r_wait_bus_req", bus_req,      0);
    resetn = 0; bus_data_ok = 1;
    #1;
    check("r_async_dataok", data_data_ok, 0);
    check("r_async_idok",   inst_data_ok, 0);
    check("r_async_busreq", bus_req,      0);
    tick();
    resetn = 1;
    #3;
    check("r_late_dataok",  data_data_ok, 0);
    check("r_late_idok",    inst_data_ok, 0);
    tick();
    bus_data_ok = 0; data_req = 1; data_addr = 32'h3000_0004; bus_addr_ok = 1;
    #3;
    check("r_idle_busreq",  bus_req,      1);
    check("r_idle_addrok",  data_addr_ok, 1);
    tick();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #3;
    check("r_after_dataok", data_data_ok, 1);
    $display("txn read   addr=30000004 after reset");
    tick();
    idle_inputs();

    // ---------------- stray response in IDLE
    bus_data_ok = 1; bus_rdata = 32'hFFFF_FFFF;
    #3;
    check("x_inst_dataok",  inst_data_ok, 0);
    check("x_data_dataok",  data_data_ok, 0);
    tick();
    bus_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC0_0010; bus_addr_ok = 1;
    #3;
    check("x_idle_busreq",  bus_req,      1);
    check("x_inst_addrok",  inst_addr_ok, 1);
    tick();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0000_0042;
    #3;
    check("x_inst_dataok2", inst_data_ok, 1);
    check("x_inst_rdata",   inst_rdata,   32'h0000_0042);
    $display("txn fetch  addr=bfc00010 after stray response");
    tick();
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
